led_mode_sched: RTL and testbench

Controller that owns the 16-LED bank on the board and schedules which pattern generator drives it: bounce, fill, blink or static-from-switches.
- Contains a shared tick prescaler whose rate is selected by `speed`.
- Contains a button-driven mode sequencer, with button synchronisation and edge detection.
- Registers the `led` output.
- Sits between the board I/O (button, switches) and the LED pins. Replaces free-running single-pattern blocks.

---
 rtl/led_mode_sched.sv | 218 +++++++++++++++++++++
 tb/tb_led_mode_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_sched.sv
// led_mode_sched: owns the 16-LED bank and decides which pattern drives it.
//
// Four pattern modes (BOUNCE, FILL, BLINK, STATIC) share one tick prescaler
// whose period is DIV_BASE >> speed. A synchronised, edge-detected button
// steps through the modes. Entering a mode restarts that mode's pattern from
// its reset value. The state of inactive modes is frozen.
//
// Optional feature, enabled by defining the macro AUTO_CYCLE_EN:
//   the mode also advances on its own after AUTO_TICKS ticks without a press.
// With the macro undefined, the auto counter is not built at all.

module led_mode_sched #(
  parameter int DIV_BASE   = 33554432,  // ticks period at speed=0; power of two, >= 8
  parameter int AUTO_TICKS = 64         // ticks per mode before auto-advance
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic [15:0] sw,
  input  logic [1:0]  speed,
  output logic [15:0] led,
  output logic [1:0]  mode
);

  localparam int CNT_W = $clog2(DIV_BASE);

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_FILL   = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_STATIC = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  // Elaboration-time guards on the parameters.
  if (DIV_BASE < 8 || (DIV_BASE & (DIV_BASE - 1)) != 0) begin : g_bad_div_base
    $error("led_mode_sched: DIV_BASE must be a power of two and at least 8");
  end
  if (AUTO_TICKS < 1) begin : g_bad_auto_ticks
    $error("led_mode_sched: AUTO_TICKS must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Tick prescaler
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] period_m1;
  logic             tick;

  // Terminal count for the selected speed; the >= compare lets a switch to a
  // shorter period tick at once instead of running the counter past it.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (here via unconditional assignments) so no latch is inferred.
    period_m1 = CNT_W'((DIV_BASE >> speed) - 1);
    tick      = (cnt_q >= period_m1);
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
  end

  // Prescaler count register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers are written with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Button synchroniser and rising-edge detect
  // ---------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic sync3_q;
  logic btn_press;

  // Two flops resolve metastability; the third holds last cycle's level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= btn_next;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // One-cycle pulse per rising edge, so a held button advances only once.
  assign btn_press = sync2_q & ~sync3_q;

  // ---------------------------------------------------------------------------
  // Mode-advance request (button, optionally also the auto counter)
  // ---------------------------------------------------------------------------
  logic press;

`ifdef AUTO_CYCLE_EN
  localparam int AUTO_W = $clog2(AUTO_TICKS + 1);

  logic [AUTO_W-1:0] auto_q;
  logic [AUTO_W-1:0] auto_d;
  logic              auto_press;

  // A simultaneous button and auto press merge into a single advance.
  assign auto_press = (auto_q == AUTO_W'(AUTO_TICKS));
  assign press      = btn_press | auto_press;

  // Count ticks spent in the current mode; any advance restarts the count.
  always_comb begin
    auto_d = auto_q;
    if (press) begin
      auto_d = '0;
    end else if (tick) begin
      auto_d = auto_q + 1'b1;
    end
  end

  // Auto-advance counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_q <= '0;
    end else begin
      auto_q <= auto_d;
    end
  end
`else
  assign press = btn_press;
`endif

  // ---------------------------------------------------------------------------
  // Mode sequencer, pattern state and LED register
  // ---------------------------------------------------------------------------
  mode_e       mode_q;
  mode_e       mode_next;
  logic [3:0]  pos_q;      // lit LED index in BOUNCE
  dir_e        dir_q;      // BOUNCE travel direction
  logic [4:0]  level_q;    // number of lit LEDs in FILL, 0..16
  logic        phase_q;    // BLINK on/off phase
  logic [15:0] led_q;
  logic [15:0] pattern_d;

  // Mode that a press moves to; the 2-bit add wraps STATIC back to BOUNCE.
  assign mode_next = mode_e'(mode_q + 2'd1);

  // Pattern of the current mode, registered into led_q on the next edge.
  always_comb begin
    pattern_d = 16'h0000;
    unique case (mode_q)
      MODE_BOUNCE: pattern_d = 16'h0001 << pos_q;
      MODE_FILL:   pattern_d = ~(16'hFFFF >> level_q);
      MODE_BLINK:  pattern_d = {16{phase_q}};
      MODE_STATIC: pattern_d = sw;
    endcase
  end

  // Mode FSM: a press wins over a coincident tick (which is then dropped);
  // otherwise a tick advances only the active mode's pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_BOUNCE;
      pos_q   <= 4'd15;
      dir_q   <= DIR_RIGHT;
      level_q <= 5'd0;
      phase_q <= 1'b0;
      led_q   <= 16'h8000;
    end else begin
      led_q <= pattern_d;

      if (press) begin
        mode_q <= mode_next;
        // Restart the pattern of the mode being entered.
        unique case (mode_next)
          MODE_BOUNCE: begin
            pos_q <= 4'd15;
            dir_q <= DIR_RIGHT;
          end
          MODE_FILL:   level_q <= 5'd0;
          MODE_BLINK:  phase_q <= 1'b0;
          MODE_STATIC: ;
        endcase
      end else if (tick) begin
        unique case (mode_q)
          MODE_BOUNCE: begin
            // Each end is held for one tick while the direction flips.
            if (dir_q == DIR_RIGHT) begin
              if (pos_q == 4'd0) begin
                dir_q <= DIR_LEFT;
              end else begin
                pos_q <= pos_q - 4'd1;
              end
            end else begin
              if (pos_q == 4'd15) begin
                dir_q <= DIR_RIGHT;
              end else begin
                pos_q <= pos_q + 4'd1;
              end
            end
          end
          MODE_FILL:   level_q <= (level_q == 5'd16) ? 5'd0 : level_q + 5'd1;
          MODE_BLINK:  phase_q <= ~phase_q;
          MODE_STATIC: ;
        endcase
      end
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_sched.sv
// Testbench for led_mode_sched (DIV_BASE=8, AUTO_TICKS=4).
// Directed steps from the test plan, then randomized button/switch/speed/reset
// traffic, all compared every cycle against a behavioural model.

module tb_led_mode_sched;

  localparam int DIV    = 8;
  localparam int AUTO_N = 4;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        btn_next = 1'b0;
  logic [15:0] sw       = 16'h0000;
  logic [1:0]  speed    = 2'd0;
  logic [15:0] led;
  logic [1:0]  mode;

  int n_cmp = 0;
  int n_bad = 0;

  led_mode_sched #(
    .DIV_BASE  (DIV),
    .AUTO_TICKS(AUTO_N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_next(btn_next),
    .sw      (sw),
    .speed   (speed),
    .led     (led),
    .mode    (mode)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model. BOUNCE is a 32-step cycle index: steps 0..15 walk the
  // dot 15->0, steps 16..31 walk it 0->15, so each end is shown twice.
  // ---------------------------------------------------------------------------
  int          m_mode;
  int          m_bk;
  int          m_level;
  int          m_phase;
  int          m_cnt;
  int          m_auto;
  logic [15:0] m_led;
  bit          hist[$];   // btn_next as sampled at each post-reset edge

  task automatic model_reset();
    m_mode  = 0;
    m_bk    = 0;
    m_level = 0;
    m_phase = 0;
    m_cnt   = 0;
    m_auto  = 0;
    m_led   = 16'h8000;
    hist.delete();
    repeat (3) hist.push_back(1'b0);
  endtask

  function automatic logic [15:0] m_pattern();
    int v;
    int pos;
    case (m_mode)
      0: begin
        pos = (m_bk < 16) ? 15 - m_bk : m_bk - 16;
        v   = 1 << pos;
      end
      1:       v = 'hFFFF << (16 - m_level);
      2:       v = (m_phase != 0) ? 'hFFFF : 0;
      default: v = int'(sw);
    endcase
    return v[15:0];
  endfunction

  // Advance the model over one rising edge, using the inputs seen at that edge.
  task automatic model_edge();
    logic [15:0] nl;
    int          period;
    bit          tick;
    bit          press;
    nl     = m_pattern();
    period = DIV >> speed;
    tick   = (m_cnt >= period - 1);
    m_cnt  = tick ? 0 : m_cnt + 1;
    // A level first sampled at edge n becomes a press acted on at edge n+2.
    press  = hist[hist.size() - 2] && !hist[hist.size() - 3];
    hist.push_back(btn_next);
    if (hist.size() > 4) void'(hist.pop_front());
`ifdef AUTO_CYCLE_EN
    if (m_auto == AUTO_N) press = 1'b1;
    if (press)      m_auto = 0;
    else if (tick)  m_auto = m_auto + 1;
`endif
    if (press) begin
      m_mode = (m_mode + 1) % 4;
      case (m_mode)
        0:       m_bk    = 0;
        1:       m_level = 0;
        2:       m_phase = 0;
        default: ;
      endcase
    end else if (tick) begin
      case (m_mode)
        0:       m_bk    = (m_bk + 1) % 32;
        1:       m_level = (m_level + 1) % 17;
        2:       m_phase = 1 - m_phase;
        default: ;
      endcase
    end
    m_led = nl;
  endtask

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: model steps at the edge, DUT outputs compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check("mode", {14'b0, mode}, 16'(m_mode));
    check("led", led, m_led);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press_hold(input int n);
    btn_next = 1'b1;
    run(n);
    btn_next = 1'b0;
  endtask

  // Assert reset between clock edges and check it takes effect without one.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_led", led, 16'h8000);
    check("async_rst_mode", {14'b0, mode}, 16'h0000);
    run(2);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int         changes;
    logic [1:0] prev;
    bit         pend;
    int         r;

    model_reset();
    async_reset();

`ifndef AUTO_CYCLE_EN
    // First tick lands on the 8th edge after release; led follows one later.
    run(7);
    cycle();
    check("pre_first_tick", led, 16'h8000);
    cycle();
    check("first_tick", led, 16'h4000);

    // Bounce end: 15 ticks reach LED0, tick 16 dwells, tick 17 turns back.
    run(112);
    check("bounce_tick15", led, 16'h0001);
    run(8);
    check("bounce_dwell", led, 16'h0001);
    run(8);
    check("bounce_return", led, 16'h0002);

    // A button held for 20 cycles advances the mode exactly once.
    changes  = 0;
    pend     = 1'b0;
    prev     = mode;
    btn_next = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (pend) begin
        check("fill_entry_led", led, 16'h0000);
        pend = 1'b0;
      end
      if (mode != prev) begin
        changes++;
        pend = 1'b1;
        prev = mode;
      end
    end
    btn_next = 1'b0;
    check("held_press_count", 16'(changes), 16'd1);
    check("held_press_mode", {14'b0, mode}, 16'd1);
    run(4);
    press_hold(3);
    run(3);
    check("second_press_mode", {14'b0, mode}, 16'd2);

    // FILL: fresh start, press acted on at edge 3, ticks every 8 edges.
    async_reset();
    press_hold(3);
    run(125);
    cycle();
    check("fill_full", led, 16'hFFFF);
    run(7);
    cycle();
    check("fill_wrap", led, 16'h0000);
    run(4);                 // prescaler count is now 5
    speed = 2'd3;
    cycle();                // immediate tick: level 0 -> 1
    cycle();
    check("speed_up_tick", led, 16'h8000);
    cycle();
    check("speed3_tick2", led, 16'hC000);
    cycle();
    check("speed3_tick3", led, 16'hE000);

    // STATIC: LEDs follow the switches regardless of speed.
    sw = 16'hA5A5;
    press_hold(2);
    run(3);
    press_hold(2);
    run(3);
    check("static_mode", {14'b0, mode}, 16'd3);
    check("static_led", led, 16'hA5A5);
    speed = 2'd0;
    run(5);
    check("static_speed0", led, 16'hA5A5);
    speed = 2'd2;
    run(5);
    check("static_speed2", led, 16'hA5A5);
    speed = 2'd0;
    async_reset();

    // Press coincident with the tick that would move the dot off LED7.
    run(69);
    btn_next = 1'b1;
    run(2);
    check("pre_coincide_mode", {14'b0, mode}, 16'd0);
    cycle();
    check("coincide_mode", {14'b0, mode}, 16'd1);
    cycle();
    check("coincide_led", led, 16'h0000);
    btn_next = 1'b0;
    run(4);
`else
    // Auto-advance: ticks at edges 8..32 fill the counter; advance at edge 33.
    run(32);
    check("auto_before", {14'b0, mode}, 16'd0);
    cycle();
    check("auto_advance", {14'b0, mode}, 16'd1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 40)       btn_next = ~btn_next;
      else if (r < 55)  speed = 2'($urandom);
      else if (r < 70)  sw = 16'($urandom);
      else if (r < 73)  async_reset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
